// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: background scrubber for a bank of triplicated registers.
// Walks the bank one word at a time and votes the three copies bitwise.
// When a copy disagrees, it writes the voted word back to all three copies.
// User writes share the bank's single write port and always take priority.
module tmr_scrub_ctrl #(
  parameter int DW     = 8,
  parameter int NW     = 16,
  parameter int AW     = 4,
  parameter int PERIOD = 1024,
  parameter int CW     = 16
) (
  input  logic          c,
  input  logic          rn,
  input  logic          en,
  input  logic          clr,
  input  logic          uw_req,
  input  logic [AW-1:0] uw_addr,
  input  logic [DW-1:0] uw_data,
  output logic          uw_ack,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_q1,
  input  logic [DW-1:0] m_q2,
  input  logic [DW-1:0] m_q3,
  output logic          busy,
  output logic          pass_done,
  output logic          err_p,
  output logic [AW-1:0] err_addr,
  output logic [2:0]    fault_map,
  output logic [CW-1:0] err_cnt
);

  // Wait counter only needs to reach PERIOD-1.
  localparam int WCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((PERIOD > 0) ? PERIOD - 1 : 0);
  localparam logic [AW-1:0]  LAST_WORD = AW'(NW - 1);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, NXT, WAIT} state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       ptr_reg, ptr_next;
  logic [WCW-1:0]      wait_reg, wait_next;
  logic [DW-1:0]       wd_reg;
  logic                pass_done_reg, err_p_reg;
  logic [AW-1:0]       err_addr_reg;
  logic [2:0]          fault_map_reg;
  logic [CW-1:0]       err_cnt_reg;

  logic [2:0][DW-1:0]  q_in;
  logic [2:0][DW-1:0]  cap;
  logic [2:0]          diff;
  logic [DW-1:0]       vote;
  logic                mismatch;
  logic                hit;
  logic                record;
  logic                wrap;

  assign q_in = {m_q3, m_q2, m_q1};

  // Bitwise majority of the three captured copies.
  assign vote     = (cap[0] & cap[1]) | (cap[0] & cap[2]) | (cap[1] & cap[2]);
  assign mismatch = |diff;

  // A user write landing on the word being checked or repaired makes our captured data stale.
  assign hit = uw_req && (uw_addr == ptr_reg) && (state_reg == CHK || state_reg == WR);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_copy
      logic [DW-1:0] cap_reg;

      // Capture one raw copy during an unstalled RD cycle.
      always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
          cap_reg <= '0;
        end else if (state_reg == RD && !uw_req) begin
          cap_reg <= q_in[gi];
        end
      end

      assign cap[gi]  = cap_reg;
      assign diff[gi] = (cap_reg != vote);
    end
  endgenerate

  // State, pointer and wait counter registers.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      wait_reg  <= wait_next;
    end
  end

  // Next-state logic; any user request freezes the scrub sequence except for a collision.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    wait_next  = wait_reg;
    record     = 1'b0;
    wrap       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!uw_req && en) state_next = RD;
      end
      RD: begin
        if (!uw_req) state_next = CHK;
      end
      CHK: begin
        if (hit) begin
          // The user data supersedes the repair, but the error is still reported.
          record     = mismatch;
          state_next = NXT;
        end else if (!uw_req) begin
          record     = mismatch;
          state_next = mismatch ? WR : NXT;
        end
      end
      WR: begin
        if (hit || !uw_req) state_next = NXT;
      end
      NXT: begin
        if (!uw_req) begin
          if (ptr_reg == LAST_WORD) begin
            ptr_next = '0;
            wrap     = 1'b1;
            if (PERIOD > 0) state_next = WAIT;
            else            state_next = en ? RD : IDLE;
          end else begin
            ptr_next   = ptr_reg + 1'b1;
            state_next = en ? RD : IDLE;
          end
        end
      end
      WAIT: begin
        if (!uw_req) begin
          if (!en) begin
            state_next = IDLE;
            wait_next  = '0;
          end else if (wait_reg == WAIT_LAST) begin
            state_next = RD;
            wait_next  = '0;
          end else begin
            wait_next = wait_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Voted repair data, loaded when the check completes.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      wd_reg <= '0;
    end else if (state_reg == CHK && !uw_req) begin
      wd_reg <= vote;
    end
  end

  // Error statistics and pulses; clear beats a coincident increment.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      pass_done_reg <= 1'b0;
      err_p_reg     <= 1'b0;
      err_addr_reg  <= '0;
      fault_map_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      pass_done_reg <= wrap;
      err_p_reg     <= record;
      if (record) err_addr_reg <= ptr_reg;
      if (clr) begin
        fault_map_reg <= '0;
        err_cnt_reg   <= '0;
      end else if (record) begin
        fault_map_reg <= diff;
        if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
      end
    end
  end

  assign uw_ack    = uw_req;
  assign m_we      = uw_req || (state_reg == WR);
  assign m_addr    = uw_req ? uw_addr : ptr_reg;
  assign m_wd      = uw_req ? uw_data : wd_reg;
  assign busy      = (state_reg == RD) || (state_reg == CHK) ||
                     (state_reg == WR) || (state_reg == NXT);
  assign pass_done = pass_done_reg;
  assign err_p     = err_p_reg;
  assign err_addr  = err_addr_reg;
  assign fault_map = fault_map_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Testbench for tmr_scrub_ctrl: a modelled TMR bank on the main instance, plus
// a second small-counter instance with a fixed faulty bank for saturation and clear.
`timescale 1ns/1ps
module tb_tmr_scrub_ctrl;

  logic c = 1'b0, rn = 1'b0, en = 1'b0, clr = 1'b0, uw_req = 1'b0;
  logic [3:0] uw_addr = '0;
  logic [7:0] uw_data = '0;
  logic uw_ack, m_we, busy, pass_done, err_p;
  logic [3:0] m_addr, err_addr;
  logic [7:0] m_wd, m_q1, m_q2, m_q3;
  logic [2:0] fault_map;
  logic [15:0] err_cnt;

  logic en2 = 1'b0, clr2 = 1'b0, uw_req2 = 1'b0;
  logic [3:0] uw_addr2 = '0;
  logic [7:0] uw_data2 = '0;
  logic uw_ack2, m_we2, busy2, pass_done2, err_p2;
  logic [3:0] m_addr2, err_addr2;
  logic [7:0] m_wd2, m_q1_2, m_q2_2, m_q3_2;
  logic [2:0] fault_map2;
  logic [1:0] err_cnt2;

  always #5 c = ~c;

  tmr_scrub_ctrl dut (
    .c(c), .rn(rn), .en(en), .clr(clr), .uw_req(uw_req), .uw_addr(uw_addr),
    .uw_data(uw_data), .uw_ack(uw_ack), .m_addr(m_addr), .m_we(m_we), .m_wd(m_wd),
    .m_q1(m_q1), .m_q2(m_q2), .m_q3(m_q3), .busy(busy), .pass_done(pass_done),
    .err_p(err_p), .err_addr(err_addr), .fault_map(fault_map), .err_cnt(err_cnt)
  );

  tmr_scrub_ctrl #(.DW(8), .NW(16), .AW(4), .PERIOD(0), .CW(2)) dut2 (
    .c(c), .rn(rn), .en(en2), .clr(clr2), .uw_req(uw_req2), .uw_addr(uw_addr2),
    .uw_data(uw_data2), .uw_ack(uw_ack2), .m_addr(m_addr2), .m_we(m_we2), .m_wd(m_wd2),
    .m_q1(m_q1_2), .m_q2(m_q2_2), .m_q3(m_q3_2), .busy(busy2), .pass_done(pass_done2),
    .err_p(err_p2), .err_addr(err_addr2), .fault_map(fault_map2), .err_cnt(err_cnt2)
  );

  function automatic logic [7:0] base(input logic [3:0] a);
    return 8'hA5 ^ {a, ~a};
  endfunction

  // Bank model for the main instance
  logic [7:0] b1 [16];
  logic [7:0] b2 [16];
  logic [7:0] b3 [16];
  logic       bank_init = 1'b0, cor_req = 1'b0;
  logic [1:0] cor_copy = '0;
  logic [3:0] cor_addr = '0;
  logic [7:0] cor_mask = '0;

  always @(posedge c) begin
    if (bank_init) begin
      for (int i = 0; i < 16; i++) begin
        b1[i] <= base(4'(i));
        b2[i] <= base(4'(i));
        b3[i] <= base(4'(i));
      end
    end else if (m_we) begin
      b1[m_addr] <= m_wd;
      b2[m_addr] <= m_wd;
      b3[m_addr] <= m_wd;
    end else if (cor_req) begin
      case (cor_copy)
        2'd1:    b1[cor_addr] <= b1[cor_addr] ^ cor_mask;
        2'd2:    b2[cor_addr] <= b2[cor_addr] ^ cor_mask;
        default: b3[cor_addr] <= b3[cor_addr] ^ cor_mask;
      endcase
    end
  end

  assign m_q1 = b1[m_addr];
  assign m_q2 = b2[m_addr];
  assign m_q3 = b3[m_addr];

  // Second instance: words 0..4 permanently have copy 3 inverted
  assign m_q1_2 = base(m_addr2);
  assign m_q2_2 = base(m_addr2);
  assign m_q3_2 = base(m_addr2) ^ ((m_addr2 < 4'd5) ? 8'hFF : 8'h00);

  typedef struct packed { logic [3:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [3:0] addr; logic [2:0] fmap; } er_t;
  wr_t exp_wr_q[$];
  er_t exp_er_q[$];
  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  // Scoreboard: every scrub write and error pulse is matched against expectations
  always @(negedge c) begin : mon
    wr_t ew;
    er_t ee;
    if (rn) begin
      if (m_we && !uw_ack) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL scrub_write: unexpected write addr=%0d data=%h", m_addr, m_wd);
        end else begin
          ew = exp_wr_q.pop_front();
          if ({m_addr, m_wd} !== ew) begin
            errors++;
            $display("FAIL scrub_write: got addr=%0d data=%h want addr=%0d data=%h",
                     m_addr, m_wd, ew.addr, ew.data);
          end else $display("write  addr=%0d data=%h ok", m_addr, m_wd);
        end
      end
      if (err_p) begin
        err_pulses++;
        checks++;
        if (exp_er_q.size() == 0) begin
          errors++;
          $display("FAIL err_event: unexpected err_p addr=%0d fmap=%b", err_addr, fault_map);
        end else begin
          ee = exp_er_q.pop_front();
          if ({err_addr, fault_map} !== ee) begin
            errors++;
            $display("FAIL err_event: got addr=%0d fmap=%b want addr=%0d fmap=%b",
                     err_addr, fault_map, ee.addr, ee.fmap);
          end else $display("error  addr=%0d fmap=%b ok", err_addr, fault_map);
        end
      end
      if (m_we2) begin
        checks++;
        if (m_wd2 !== base(m_addr2)) begin
          errors++;
          $display("FAIL dut2_write: addr=%0d got %h want %h", m_addr2, m_wd2, base(m_addr2));
        end
      end
    end
  end

  task automatic do_reset();
    rn = 1'b0; en = 1'b0; clr = 1'b0; uw_req = 1'b0; en2 = 1'b0; clr2 = 1'b0;
    repeat (2) @(negedge c);
    rn = 1'b1;
    @(negedge c);
  endtask

  task automatic corrupt(input logic [1:0] cp, input logic [3:0] a, input logic [7:0] mask);
    @(negedge c);
    cor_copy = cp; cor_addr = a; cor_mask = mask; cor_req = 1'b1;
    @(negedge c);
    cor_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge c);
    checks++;
    if ({uw_ack, m_we, busy, pass_done, err_p} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {uw_ack, m_we, busy, pass_done, err_p});
    end
    checks++;
    if ({m_addr, m_wd, err_addr} !== 16'h0) begin
      errors++; $display("FAIL reset_addr_data: m_addr=%0d m_wd=%h err_addr=%0d want 0", m_addr, m_wd, err_addr);
    end
    checks++;
    if (fault_map !== 3'b0 || err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin
      errors++; $display("FAIL reset_stats: fmap=%b cnt=%0d cnt2=%0d want 0", fault_map, err_cnt, err_cnt2);
    end
    $display("reset  checked");
    rn = 1'b1;
    @(negedge c);
  endtask

  task automatic test_clean_pass();
    int busy_n = 0, idle_n = 1, pd_n = 0;
    bit seen = 0, back = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge c);
      if (pass_done) seen = 1;
      else if (busy) busy_n++;
    end
    checks++;
    if (!seen || busy_n != 48) begin
      errors++; $display("FAIL clean_pass_busy: got %0d cycles pass_done=%0d want 48 and 1", busy_n, seen);
    end
    for (int i = 0; i < 1100 && !back; i++) begin
      @(negedge c);
      if (busy) back = 1;
      else begin
        idle_n++;
        if (pass_done) pd_n++;
      end
    end
    checks++;
    if (!back || idle_n != 1024 || pd_n != 0) begin
      errors++; $display("FAIL clean_pass_wait: got %0d idle cycles extra_pd=%0d want 1024 and 0", idle_n, pd_n);
    end
    checks++;
    if (m_addr !== 4'd0) begin
      errors++; $display("FAIL clean_pass_restart: m_addr=%0d want 0", m_addr);
    end
    $display("clean  busy=%0d wait=%0d", busy_n, idle_n);
    en = 1'b0;
  endtask

  task automatic test_correct();
    int busy_n = 0, p0;
    bit seen = 0;
    do_reset();
    corrupt(2'd2, 4'd5, 8'h01);
    exp_wr_q.push_back('{addr: 4'd5, data: base(4'd5)});
    exp_er_q.push_back('{addr: 4'd5, fmap: 3'b010});
    p0 = err_pulses;
    en = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge c);
      if (pass_done) seen = 1;
      else if (busy) busy_n++;
    end
    checks++;
    if (!seen || busy_n != 49) begin
      errors++; $display("FAIL correct_busy: got %0d cycles want 49", busy_n);
    end
    checks++;
    if (err_cnt !== 16'd1 || err_addr !== 4'd5 || fault_map !== 3'b010 || err_pulses - p0 != 1) begin
      errors++; $display("FAIL correct_stats: cnt=%0d addr=%0d fmap=%b pulses=%0d want 1 5 010 1",
                         err_cnt, err_addr, fault_map, err_pulses - p0);
    end
    checks++;
    if (b2[5] !== base(4'd5) || exp_wr_q.size() != 0) begin
      errors++; $display("FAIL correct_repair: b2[5]=%h pending=%0d want %h 0", b2[5], exp_wr_q.size(), base(4'd5));
    end
    $display("correct word 5 cnt=%0d", err_cnt);
    en = 1'b0;
  endtask

  task automatic test_user_stall();
    bit found = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge c);
      if (busy && m_addr == 4'd2) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL stall_reach_rd2: timeout got m_addr=%0d want 2", m_addr);
    end
    uw_addr = 4'd9; uw_data = 8'h5A; uw_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge c);
      #1;
      checks++;
      if (!uw_ack || !m_we || m_addr !== 4'd9 || m_wd !== 8'h5A || !busy) begin
        errors++; $display("FAIL stall_grant%0d: ack=%b we=%b addr=%0d wd=%h busy=%b want 1 1 9 5a 1",
                           k, uw_ack, m_we, m_addr, m_wd, busy);
      end
    end
    @(negedge c);
    uw_req = 1'b0;
    #1;
    checks++;
    if (uw_ack || m_we || m_addr !== 4'd2 || !busy) begin
      errors++; $display("FAIL stall_resume: ack=%b we=%b addr=%0d busy=%b want 0 0 2 1", uw_ack, m_we, m_addr, busy);
    end
    repeat (3) @(negedge c);
    checks++;
    if (m_addr !== 4'd3 || !busy || b1[9] !== 8'h5A || b3[9] !== 8'h5A) begin
      errors++; $display("FAIL stall_advance: addr=%0d b1[9]=%h b3[9]=%h want 3 5a 5a", m_addr, b1[9], b3[9]);
    end
    $display("stall  user write at 9 acked 3 cycles");
    en = 1'b0;
  endtask

  task automatic test_collision();
    bit found = 0, seen = 0;
    int p0;
    do_reset();
    corrupt(2'd3, 4'd7, 8'h80);
    exp_er_q.push_back('{addr: 4'd7, fmap: 3'b100});
    p0 = err_pulses;
    en = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge c);
      if (busy && m_addr == 4'd7) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL coll_reach_rd7: timeout got m_addr=%0d want 7", m_addr);
    end
    @(negedge c);
    uw_addr = 4'd7; uw_data = 8'h3C; uw_req = 1'b1;
    repeat (2) @(negedge c);
    uw_req = 1'b0;
    #1;
    checks++;
    if (m_we || m_addr !== 4'd7 || !busy || err_cnt !== 16'd1) begin
      errors++; $display("FAIL coll_nxt: we=%b addr=%0d busy=%b cnt=%0d want 0 7 1 1", m_we, m_addr, busy, err_cnt);
    end
    @(negedge c);
    checks++;
    if (m_addr !== 4'd8 || !busy) begin
      errors++; $display("FAIL coll_advance: addr=%0d busy=%b want 8 1", m_addr, busy);
    end
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge c);
      if (pass_done) seen = 1;
    end
    checks++;
    if (!seen || err_cnt !== 16'd1 || err_pulses - p0 != 1 ||
        b1[7] !== 8'h3C || b2[7] !== 8'h3C || b3[7] !== 8'h3C) begin
      errors++; $display("FAIL coll_result: pd=%0d cnt=%0d pulses=%0d b[7]=%h/%h/%h want 1 1 1 3c",
                         seen, err_cnt, err_pulses - p0, b1[7], b2[7], b3[7]);
    end
    $display("coll   word 7 user-overwritten cnt=%0d", err_cnt);
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    bit found = 0;
    do_reset();
    corrupt(2'd1, 4'd3, 8'h10);
    exp_wr_q.push_back('{addr: 4'd3, data: base(4'd3)});
    exp_er_q.push_back('{addr: 4'd3, fmap: 3'b001});
    en = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge c);
      if (err_p) found = 1;
    end
    checks++;
    if (!found || !m_we || m_addr !== 4'd3) begin
      errors++; $display("FAIL endrop_wr: found=%0d we=%b addr=%0d want 1 1 3", found, m_we, m_addr);
    end
    en = 1'b0;
    @(negedge c);
    checks++;
    if (!busy || m_we || m_addr !== 4'd3) begin
      errors++; $display("FAIL endrop_nxt: busy=%b we=%b addr=%0d want 1 0 3", busy, m_we, m_addr);
    end
    @(negedge c);
    repeat (3) @(negedge c);
    checks++;
    if (busy || m_addr !== 4'd4 || b1[3] !== base(4'd3)) begin
      errors++; $display("FAIL endrop_idle: busy=%b addr=%0d b1[3]=%h want 0 4 %h", busy, m_addr, b1[3], base(4'd3));
    end
    en = 1'b1;
    @(negedge c);
    checks++;
    if (!busy || m_addr !== 4'd4) begin
      errors++; $display("FAIL endrop_resume: busy=%b addr=%0d want 1 4", busy, m_addr);
    end
    #2 rn = 1'b0;
    #1;
    checks++;
    if ({uw_ack, m_we, busy, pass_done, err_p, m_addr, m_wd, err_addr, fault_map, err_cnt} !== '0) begin
      errors++; $display("FAIL async_reset_outputs: busy=%b addr=%0d wd=%h cnt=%0d fmap=%b want all 0",
                         busy, m_addr, m_wd, err_cnt, fault_map);
    end
    @(negedge c);
    rn = 1'b1;
    @(negedge c);
    checks++;
    if (!busy || m_addr !== 4'd0) begin
      errors++; $display("FAIL async_reset_restart: busy=%b addr=%0d want 1 0", busy, m_addr);
    end
    $display("endrop ptr retained, reset restarts at 0");
    en = 1'b0;
  endtask

  task automatic test_reset_mid_wr();
    bit found = 0;
    do_reset();
    corrupt(2'd2, 4'd1, 8'h04);
    exp_wr_q.push_back('{addr: 4'd1, data: base(4'd1)});
    exp_er_q.push_back('{addr: 4'd1, fmap: 3'b010});
    en = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge c);
      if (err_p) found = 1;
    end
    checks++;
    if (!found || !m_we || m_addr !== 4'd1) begin
      errors++; $display("FAIL midwr_reach: found=%0d we=%b addr=%0d want 1 1 1", found, m_we, m_addr);
    end
    #2 rn = 1'b0;
    #1;
    checks++;
    if (m_we || busy || m_addr !== 4'd0) begin
      errors++; $display("FAIL midwr_drop: we=%b busy=%b addr=%0d want 0 0 0", m_we, busy, m_addr);
    end
    en = 1'b0;
    @(negedge c);
    rn = 1'b1;
    repeat (2) @(negedge c);
    checks++;
    if (busy || b2[1] !== (base(4'd1) ^ 8'h04)) begin
      errors++; $display("FAIL midwr_nowrite: busy=%b b2[1]=%h want 0 %h", busy, b2[1], base(4'd1) ^ 8'h04);
    end
    $display("midwr  write aborted by reset");
    corrupt(2'd2, 4'd1, 8'h04);
  endtask

  task automatic test_sat();
    int n = 0, expc;
    bit seen = 0;
    en2 = 1'b1;
    for (int i = 0; i < 400 && n < 6; i++) begin
      @(negedge c);
      if (err_p2) begin
        n++;
        expc = (n < 3) ? n : 3;
        if (n == 6) expc = 3;
        checks++;
        if (err_cnt2 !== 2'(expc) || fault_map2 !== 3'b100 || err_addr2 !== 4'((n - 1) % 5)) begin
          errors++; $display("FAIL sat_pulse%0d: cnt=%0d fmap=%b addr=%0d want %0d 100 %0d",
                             n, err_cnt2, fault_map2, err_addr2, expc, (n - 1) % 5);
        end else $display("sat    pulse %0d cnt=%0d", n, err_cnt2);
      end
    end
    checks++;
    if (n < 6) begin
      errors++; $display("FAIL sat_timeout: got %0d pulses want 6", n);
    end
    repeat (3) @(negedge c);
    clr2 = 1'b1;
    @(negedge c);
    clr2 = 1'b0;
    checks++;
    if (!err_p2 || err_addr2 !== 4'd1 || err_cnt2 !== 2'd0 || fault_map2 !== 3'b000) begin
      errors++; $display("FAIL sat_clr_wins: errp=%b addr=%0d cnt=%0d fmap=%b want 1 1 0 000",
                         err_p2, err_addr2, err_cnt2, fault_map2);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge c);
      if (err_p2) seen = 1;
    end
    checks++;
    if (!seen || err_cnt2 !== 2'd1 || err_addr2 !== 4'd2) begin
      errors++; $display("FAIL sat_after_clr: seen=%0d cnt=%0d addr=%0d want 1 1 2", seen, err_cnt2, err_addr2);
    end
    en2 = 1'b0;
  endtask

  initial begin
    bank_init = 1'b1;
    @(negedge c);
    bank_init = 1'b0;
    test_reset();
    test_clean_pass();
    test_correct();
    test_user_stall();
    test_collision();
    test_en_drop();
    test_reset_mid_wr();
    test_sat();
    repeat (2) @(negedge c);
    checks++;
    if (exp_wr_q.size() != 0 || exp_er_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: writes=%0d errs=%0d left want 0 0", exp_wr_q.size(), exp_er_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_ctrl.md
# tmr_scrub_ctrl

Scrub scheduler and write arbiter for a bank of NW triplicated (TMR) registers of width DW. Walks the bank one word at a time, reads the three raw copies, votes bitwise, and rewrites the voted value into all three copies when any copy disagrees. Functional writes from the user port share the bank's single write port and always win. Sits between system logic and the TMR register bank; corrected-error statistics go to the health/telemetry block.

## Interface
- DW, 8: word width.
- NW, 16: number of words in the bank (≥2).
- AW, 4: address width, 2^AW ≥ NW.
- PERIOD, 1024: idle cycles between scrub passes; 0 means back-to-back passes.
- CW, 16: error counter width.

- c  in  1  clock; all logic rising-edge.
- rn  in  1  reset, asynchronous, active-low.
- en  in  1  scrub enable.
- clr  in  1  synchronous clear of err_cnt and fault_map.
- uw_req  in  1  user write request (level).
- uw_addr  in  AW  user write address.
- uw_data  in  DW  user write data.
- uw_ack  out  1  combinational grant; high in the cycle the user write is issued.
- m_addr  out  AW  bank address.
- m_we  out  1  bank write strobe; writes m_wd to all three copies.
- m_wd  out  DW  bank write data.
- m_q1, m_q2, m_q3  in  DW  raw copies of word m_addr; combinational read.
- busy  out  1  FSM in RD, CHK, WR or NXT.
- pass_done  out  1  one-cycle pulse when the last word of a pass completes.
- err_p  out  1  one-cycle pulse per corrected word.
- err_addr  out  AW  address of last corrected word.
- fault_map  out  3  bit i set if copy i+1 disagreed with vote on last corrected word.
- err_cnt  out  CW  corrected-word count, saturating at all-ones.

## Operation
- States: IDLE, RD, CHK, WR, NXT, WAIT. Reset: state IDLE, ptr 0, wait counter 0, every output 0 (m_addr 0, m_wd 0).
- IDLE: en=1 → RD next cycle; else stay.
- RD: m_addr=ptr; m_q1..3 captured into internal regs at clock edge; → CHK.
- CHK: vote v=(a&b)|(a&c)|(b&c); mismatch if any copy ≠ v. Mismatch → WR, else → NXT. On mismatch: err_p=1, err_addr=ptr, fault_map={c≠v,b≠v,a≠v}, err_cnt+1 (saturating), all registered at the CHK→WR edge.
- WR: m_we=1, m_addr=ptr, m_wd=v (registered); → NXT.
- NXT: ptr=ptr+1, wrapping NW-1 → 0. On wrap: pass_done=1; → WAIT (PERIOD>0) or RD (PERIOD=0). No wrap: en=1 → RD, en=0 → IDLE.
- WAIT: lasts exactly PERIOD cycles, then → RD; en=0 in WAIT → IDLE immediately, counter reset.
- en=0 in RD/CHK/WR: current word finishes through NXT, then IDLE. ptr retained across en toggles.
- User arbitration: uw_req=1 in any cycle → uw_ack=1, m_we=1, m_addr=uw_addr, m_wd=uw_data that cycle; FSM holds state (RD does not capture, WR does not write). Scrub resumes the cycle after uw_req falls.
- Collision: user write with uw_addr==ptr while state is CHK or WR → FSM goes to NXT when uw_req falls; scrub write for that word cancelled (captured data stale). err_cnt/err_p still reflect a mismatch already counted in CHK.
- clr: err_cnt←0, fault_map←0; if coincident with an increment, clr wins.

## Timing
- Clean word: 3 cycles (RD, CHK, NXT); corrected word: 4 (RD, CHK, WR, NXT), excluding user stalls.
- Clean pass, no user traffic: 3·NW cycles, then PERIOD cycles in WAIT.
- Bank write for a corrected word lands 2 cycles after its RD cycle.
- err_p coincides with the WR cycle; pass_done coincides with the cycle after NXT of word NW-1 (registered).
- Async reset mid-WR: m_we drops immediately, no partial write guaranteed beyond that edge; restart from ptr 0.

## Test plan
- Defaults, en=1, all copies equal: busy high 48 cycles, pass_done pulse, no m_we, next RD 1024 cycles later.
- Word 5 with m_q2 = m_q1^8'h01: err_p once, err_addr=5, fault_map=3'b010, err_cnt=1, m_we with m_wd=m_q1 at address 5.
- uw_req held 3 cycles at addr 9 while scrubber in RD at ptr 2: uw_ack 3 cycles, m_addr=9, FSM holds, resumes RD at 2.
- Word 7 corrupted; user write to addr 7 asserted in CHK: no scrub write to 7, err_cnt=1, ptr advances to 8.
- CW=2, corrupt 5 words: err_cnt saturates at 3; clr with simultaneous error → err_cnt=0.
- en dropped in WR: write completes, NXT, IDLE; rn pulsed low mid-pass: all outputs 0, ptr 0.
